// File: rtl/mste_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mste_pkg
// Description : Shared types and defaults for the Mega STE cache sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mste_pkg;

  localparam int          IDX_BITS_DEF  = 13;
  localparam logic [23:0] CACHE_TOP_DEF = 24'h400000;

  typedef enum logic [2:0] {
    ST_FLUSH  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_LOOKUP = 3'd2,
    ST_FILL   = 3'd3,
    ST_WTHRU  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Tag holds whatever word-address bits the index does not cover.
  function automatic int tag_width(input int idx_bits);
    return 23 - idx_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mste_cache_ram.sv
`default_nettype none
// ============================================================================
// Module      : mste_cache_ram
// Description : Dual-port tag/valid/data store. Port A serves lookup and line
//               writes; port B serves snoop compare/clear and flush sweep.
// Revision    : 1.0 - initial release
// ============================================================================
module mste_cache_ram
  import mste_pkg::*;
#(
  parameter int IDX_BITS = IDX_BITS_DEF,
  parameter int TAG_W    = tag_width(IDX_BITS)
) (
  input  logic                clk,
  // port A: lookup / fill / write merge
  input  logic [IDX_BITS-1:0] a_idx_i,
  input  logic                a_rd_en_i,
  output logic [TAG_W-1:0]    a_tag_o,
  output logic [15:0]         a_data_o,
  output logic                a_valid_o,
  input  logic                a_fill_i,
  input  logic [TAG_W-1:0]    a_wtag_i,
  input  logic                a_dwe_i,
  input  logic [1:0]          a_dbe_i,
  input  logic [15:0]         a_wdata_i,
  // port B: snoop / flush
  input  logic [IDX_BITS-1:0] b_idx_i,
  input  logic [TAG_W-1:0]    b_tag_i,
  input  logic                b_snoop_i,
  input  logic                b_clr_i,
  output logic                b_hit_o
);

  localparam int DEPTH = 1 << IDX_BITS;

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_mem [DEPTH];
  logic [15:0]      data_mem [DEPTH];
  logic [TAG_W-1:0] a_tag_q;
  logic [15:0]      a_data_q;

  // Valid bits are flops so lookup sees same-cycle snoop/flush effects.
  assign a_valid_o = valid_q[a_idx_i];
  assign b_hit_o   = valid_q[b_idx_i] && (tag_mem[b_idx_i] == b_tag_i);
  assign a_tag_o   = a_tag_q;
  assign a_data_o  = a_data_q;

  // Valid update: a later clear overrides a same-cycle set on the same entry.
  always_ff @(posedge clk) begin
    if (a_fill_i) valid_q[a_idx_i] <= 1'b1;
    if (b_clr_i || (b_snoop_i && b_hit_o)) valid_q[b_idx_i] <= 1'b0;
  end

  // Tag/data writes with byte strobes, and the synchronous port-A read.
  always_ff @(posedge clk) begin
    if (a_fill_i) tag_mem[a_idx_i] <= a_wtag_i;
    if (a_dwe_i) begin
      if (a_dbe_i[1]) data_mem[a_idx_i][15:8] <= a_wdata_i[15:8];
      if (a_dbe_i[0]) data_mem[a_idx_i][7:0]  <= a_wdata_i[7:0];
    end
    if (a_rd_en_i) begin
      a_tag_q  <= tag_mem[a_idx_i];
      a_data_q <= data_mem[a_idx_i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mste_cache_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mste_cache_sequencer
// Description : Direct-mapped write-through CPU cache controller for the
//               Mega STE: lookup, line fill, write-through, flush sweep and
//               DMA/blitter snoop invalidation.
// Revision    : 1.0 - initial release
// ============================================================================
module mste_cache_sequencer
  import mste_pkg::*;
#(
  parameter int          IDX_BITS  = IDX_BITS_DEF,
  parameter logic [23:0] CACHE_TOP = CACHE_TOP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable_cache,
  input  logic        cpu_req,
  input  logic        cpu_rw,
  input  logic [22:0] cpu_addr,
  input  logic [1:0]  cpu_ds,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        ram_req,
  output logic        ram_rw,
  output logic [22:0] ram_addr,
  output logic [1:0]  ram_ds,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  input  logic        ram_ack,
  input  logic        snoop_we,
  input  logic [22:0] snoop_addr,
  output logic        flushing
);

  localparam int TAG_W = tag_width(IDX_BITS);

  state_e              state_q, state_d;
  logic                en_q, pending_q, kill_q, hit_q;
  logic [IDX_BITS-1:0] sweep_q;
  logic [15:0]         rdata_q, ram_wdata_q;
  logic                ram_req_q, ram_rw_q;
  logic [22:0]         ram_addr_q;
  logic [1:0]          ram_ds_q;

  logic [IDX_BITS-1:0] w_idx;
  logic [TAG_W-1:0]    w_tag, w_a_tag;
  logic [15:0]         w_a_data;
  logic                w_a_valid, w_b_hit;
  logic                w_cacheable, w_hit, w_dis_edge, w_snoop_self;
  logic                w_rd_en, w_fill, w_dwe;
  logic [1:0]          w_dbe;
  logic [15:0]         w_wdata;

  assign w_idx        = cpu_addr[IDX_BITS-1:0];
  assign w_tag        = cpu_addr[22:IDX_BITS];
  assign w_cacheable  = enable_cache && ({cpu_addr, 1'b0} < CACHE_TOP);
  assign w_hit        = w_cacheable && w_a_valid && (w_a_tag == w_tag);
  assign w_dis_edge   = en_q && !enable_cache;
  assign w_snoop_self = snoop_we && (snoop_addr == cpu_addr);

  assign cpu_rdata = rdata_q;
  assign cpu_ack   = (state_q == ST_DONE);
  assign ram_req   = ram_req_q;
  assign ram_rw    = ram_rw_q;
  assign ram_addr  = ram_addr_q;
  assign ram_ds    = ram_ds_q;
  assign ram_wdata = ram_wdata_q;
  assign flushing  = (state_q == ST_FLUSH);

  mste_cache_ram #(
    .IDX_BITS (IDX_BITS),
    .TAG_W    (TAG_W)
  ) u_ram (
    .clk       (clk),
    .a_idx_i   (w_idx),
    .a_rd_en_i (w_rd_en),
    .a_tag_o   (w_a_tag),
    .a_data_o  (w_a_data),
    .a_valid_o (w_a_valid),
    .a_fill_i  (w_fill),
    .a_wtag_i  (w_tag),
    .a_dwe_i   (w_dwe),
    .a_dbe_i   (w_dbe),
    .a_wdata_i (w_wdata),
    .b_idx_i   (flushing ? sweep_q : snoop_addr[IDX_BITS-1:0]),
    .b_tag_i   (snoop_addr[22:IDX_BITS]),
    .b_snoop_i (snoop_we && !flushing),
    .b_clr_i   (flushing),
    .b_hit_o   (w_b_hit)
  );

  // Next-state and array-control decode.
  always_comb begin
    state_d = state_q;
    w_rd_en = 1'b0;
    w_fill  = 1'b0;
    w_dwe   = 1'b0;
    w_dbe   = 2'b11;
    w_wdata = ram_rdata;
    case (state_q)
      ST_FLUSH:  if (sweep_q == {IDX_BITS{1'b1}}) state_d = ST_IDLE;
      ST_IDLE: begin
        if (w_dis_edge) begin
          state_d = ST_FLUSH;
        end else if (cpu_req) begin
          state_d = ST_LOOKUP;
          w_rd_en = 1'b1;
        end
      end
      ST_LOOKUP: begin
        if (!cpu_rw)    state_d = ST_WTHRU;
        else if (w_hit) state_d = ST_DONE;
        else            state_d = ST_FILL;
      end
      ST_FILL: begin
        if (ram_ack) begin
          state_d = ST_DONE;
          // A snoop to this very word during the fill kills allocation.
          if (w_cacheable && !kill_q && !w_snoop_self) begin
            w_fill = 1'b1;
            w_dwe  = 1'b1;
          end
        end
      end
      ST_WTHRU: begin
        if (ram_ack) begin
          state_d = ST_DONE;
          if (w_cacheable && hit_q) begin
            w_dwe   = 1'b1;
            w_dbe   = cpu_ds;
            w_wdata = cpu_wdata;
          end
        end
      end
      ST_DONE:  state_d = (pending_q || w_dis_edge) ? ST_FLUSH : ST_IDLE;
      default:  state_d = ST_FLUSH;
    endcase
  end

  // State, sweep counter, pending flush and bus-side registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FLUSH;
      sweep_q     <= '0;
      en_q        <= 1'b0;
      pending_q   <= 1'b0;
      kill_q      <= 1'b0;
      hit_q       <= 1'b0;
      rdata_q     <= '0;
      ram_req_q   <= 1'b0;
      ram_rw_q    <= 1'b1;
      ram_addr_q  <= '0;
      ram_ds_q    <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= enable_cache;
      sweep_q <= (state_q == ST_FLUSH) ? sweep_q + IDX_BITS'(1) : '0;
      if (state_d == ST_FLUSH)
        pending_q <= 1'b0;
      else if (w_dis_edge && (state_q != ST_IDLE) && (state_q != ST_FLUSH))
        pending_q <= 1'b1;
      case (state_q)
        ST_LOOKUP: begin
          hit_q  <= w_hit;
          kill_q <= 1'b0;
          if (state_d == ST_DONE) begin
            rdata_q <= w_a_data;
          end else begin
            ram_req_q  <= 1'b1;
            ram_addr_q <= cpu_addr;
            if (cpu_rw) begin
              ram_rw_q <= 1'b1;
              ram_ds_q <= 2'b11;
            end else begin
              ram_rw_q    <= 1'b0;
              ram_ds_q    <= cpu_ds;
              ram_wdata_q <= cpu_wdata;
            end
          end
        end
        ST_FILL: begin
          if (w_snoop_self) kill_q <= 1'b1;
          if (ram_ack) begin
            ram_req_q <= 1'b0;
            rdata_q   <= ram_rdata;
          end
        end
        ST_WTHRU: begin
          if (ram_ack) begin
            ram_req_q <= 1'b0;
            ram_rw_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mste_cache_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mste_cache_sequencer
// Description : Scoreboard bench for the Mega STE cache sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mste_cache_sequencer;

  typedef struct { string name; logic chk; logic [15:0] rdata; } cpu_exp_t;
  typedef struct { string name; logic [22:0] addr; logic rw; logic [1:0] ds; logic [15:0] wdata; } ram_exp_t;
  typedef struct { string name; int act; int exp; } aux_t;

  logic        clk, reset, en_stim, resp_drop;
  logic        enable_cache, cpu_req, cpu_rw, cpu_ack;
  logic [22:0] cpu_addr, ram_addr, snoop_addr, snoop_stim_addr;
  logic [1:0]  cpu_ds, ram_ds;
  logic [15:0] cpu_wdata, cpu_rdata, ram_wdata, ram_rdata;
  logic        ram_req, ram_rw, ram_ack, snoop_we, flushing;
  logic        snoop_stim_we, snoop_resp_we, snoop_in_fill, dis_in_fill;

  cpu_exp_t cpu_q[$];
  ram_exp_t ram_q[$];
  aux_t     aux_q[$];
  logic [15:0] mem [logic [22:0]];

  int checks, fails;
  int resp_cnt;
  logic resp_busy;
  cpu_exp_t ce;
  ram_exp_t re;
  aux_t ae;
  logic [15:0] mw;

  assign enable_cache = en_stim && !resp_drop;
  assign snoop_we     = snoop_stim_we || snoop_resp_we;
  assign snoop_addr   = snoop_resp_we ? ram_addr : snoop_stim_addr;

  mste_cache_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .enable_cache (enable_cache),
    .cpu_req      (cpu_req),
    .cpu_rw       (cpu_rw),
    .cpu_addr     (cpu_addr),
    .cpu_ds       (cpu_ds),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_ack      (cpu_ack),
    .ram_req      (ram_req),
    .ram_rw       (ram_rw),
    .ram_addr     (ram_addr),
    .ram_ds       (ram_ds),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .ram_ack      (ram_ack),
    .snoop_we     (snoop_we),
    .snoop_addr   (snoop_addr),
    .flushing     (flushing)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, fails);
    $fatal(1, "watchdog");
  end

  // Initial memory image for the words the bench touches.
  function automatic logic [15:0] mem_init(input logic [22:0] a);
    case (a)
      23'h000080: return 16'hBEEF;
      23'h000100: return 16'hCAFE;
      23'h7E0000: return 16'h4E75;
      default:    return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] mem_rd(input logic [22:0] a);
    if (mem.exists(a)) return mem[a];
    return mem_init(a);
  endfunction

  // Monitor, scoreboard and memory responder (single owner of the counters).
  initial begin
    checks = 0; fails = 0; resp_cnt = 0; resp_busy = 1'b0;
    ram_ack = 1'b0; ram_rdata = 16'h0; snoop_resp_we = 1'b0; resp_drop = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && cpu_ack) begin
        if (cpu_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_ack got rdata=%h, no ack expected", cpu_rdata);
        end else begin
          ce = cpu_q.pop_front();
          if (ce.chk) begin
            checks++;
            if (cpu_rdata !== ce.rdata) begin
              fails++;
              $display("FAIL %s rdata got=%h exp=%h", ce.name, cpu_rdata, ce.rdata);
            end
          end
        end
      end
      while (aux_q.size() > 0) begin
        ae = aux_q.pop_front();
        checks++;
        if (ae.act != ae.exp) begin
          fails++;
          $display("FAIL %s got=%0d exp=%0d", ae.name, ae.act, ae.exp);
        end
      end
      if (ram_ack) ram_ack = 1'b0;
      if (!dis_in_fill) resp_drop = 1'b0;
      if (resp_busy) begin
        resp_cnt--;
        snoop_resp_we = (resp_cnt == 2) && snoop_in_fill;
        if (resp_cnt == 2 && dis_in_fill) resp_drop = 1'b1;
        if (resp_cnt == 0) begin
          mw = mem_rd(ram_addr);
          ram_rdata = mw;
          if (!ram_rw) begin
            if (ram_ds[1]) mw[15:8] = ram_wdata[15:8];
            if (ram_ds[0]) mw[7:0]  = ram_wdata[7:0];
            mem[ram_addr] = mw;
          end
          ram_ack   = 1'b1;
          resp_busy = 1'b0;
        end
      end else if (ram_req && !reset) begin
        resp_busy = 1'b1;
        resp_cnt  = 3;
        checks++;
        if (ram_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_ram_req got addr=%h rw=%b, no request expected", ram_addr, ram_rw);
        end else begin
          re = ram_q.pop_front();
          if (ram_addr !== re.addr || ram_rw !== re.rw || ram_ds !== re.ds ||
              (!re.rw && ram_wdata !== re.wdata)) begin
            fails++;
            $display("FAIL %s ram got addr=%h rw=%b ds=%b wd=%h exp addr=%h rw=%b ds=%b wd=%h",
                     re.name, ram_addr, ram_rw, ram_ds, ram_wdata, re.addr, re.rw, re.ds, re.wdata);
          end
        end
      end
    end
  end

  task automatic push_aux(input string nm, input int act, input int exp);
    aux_t a;
    a.name = nm; a.act = act; a.exp = exp;
    aux_q.push_back(a);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue one CPU access; expectations are queued before the request.
  task automatic cpu_access(input string nm, input logic rw, input logic [22:0] addr,
                            input logic [1:0] ds, input logic [15:0] wd,
                            input logic chk, input logic [15:0] exp_rd,
                            input logic exp_ram, input logic exp_hit);
    cpu_exp_t c;
    ram_exp_t r;
    int cyc;
    c.name = nm; c.chk = chk; c.rdata = exp_rd;
    cpu_q.push_back(c);
    if (exp_ram) begin
      r.name = nm; r.addr = addr; r.rw = rw; r.ds = rw ? 2'b11 : ds; r.wdata = wd;
      ram_q.push_back(r);
    end
    @(negedge clk);
    cpu_req = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_ds = ds; cpu_wdata = wd;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!cpu_ack && cyc < 200);
    push_aux({nm, "_ack"}, int'(cpu_ack), 1);
    if (exp_hit) push_aux({nm, "_latency"}, cyc, 2);
    cpu_req = 1'b0;
  endtask

  task automatic snoop(input logic [22:0] addr);
    @(negedge clk);
    snoop_stim_we = 1'b1; snoop_stim_addr = addr;
    @(negedge clk);
    snoop_stim_we = 1'b0;
  endtask

  task automatic flush_count(input string nm);
    int n;
    n = 0;
    while (flushing && n < 20000) begin
      n++;
      @(negedge clk);
    end
    push_aux(nm, n, 8192);
  endtask

  initial begin
    reset = 1'b1; en_stim = 1'b1; cpu_req = 1'b0; cpu_rw = 1'b1; cpu_addr = '0;
    cpu_ds = 2'b11; cpu_wdata = '0; snoop_stim_we = 1'b0; snoop_stim_addr = '0;
    snoop_in_fill = 1'b0; dis_in_fill = 1'b0;
    repeat (3) @(negedge clk);
    push_aux("rst_cpu_ack",   int'(cpu_ack),   0);
    push_aux("rst_cpu_rdata", int'(cpu_rdata), 0);
    push_aux("rst_ram_req",   int'(ram_req),   0);
    push_aux("rst_ram_rw",    int'(ram_rw),    1);
    push_aux("rst_ram_addr",  int'(ram_addr),  0);
    push_aux("rst_ram_ds",    int'(ram_ds),    0);
    push_aux("rst_ram_wdata", int'(ram_wdata), 0);
    push_aux("rst_flushing",  int'(flushing),  1);
    reset = 1'b0;
    flush_count("reset_flush_cycles");
    idle(2);

    //          name            rw    addr         ds     wdata     chk   exp_rd    ram   hit
    cpu_access("rd_miss",       1'b1, 23'h000080, 2'b11, 16'h0000, 1'b1, 16'hBEEF, 1'b1, 1'b0); idle(2);
    cpu_access("rd_hit",        1'b1, 23'h000080, 2'b11, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 1'b1); idle(2);
    cpu_access("wr_lo_byte",    1'b0, 23'h000080, 2'b01, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0); idle(2);
    cpu_access("rd_hit_merged", 1'b1, 23'h000080, 2'b11, 16'h0000, 1'b1, 16'hBE34, 1'b0, 1'b1); idle(2);
    snoop(23'h000080); idle(1);
    cpu_access("rd_after_snoop",1'b1, 23'h000080, 2'b11, 16'h0000, 1'b1, 16'hBE34, 1'b1, 1'b0); idle(2);
    cpu_access("rd_refilled",   1'b1, 23'h000080, 2'b11, 16'h0000, 1'b1, 16'hBE34, 1'b0, 1'b1); idle(2);
    snoop(23'h000080); idle(1);
    snoop_in_fill = 1'b1;
    cpu_access("rd_fill_killed",1'b1, 23'h000080, 2'b11, 16'h0000, 1'b1, 16'hBE34, 1'b1, 1'b0); idle(2);
    snoop_in_fill = 1'b0;
    cpu_access("rd_after_kill", 1'b1, 23'h000080, 2'b11, 16'h0000, 1'b1, 16'hBE34, 1'b1, 1'b0); idle(2);
    cpu_access("rd_byte_hit",   1'b1, 23'h000080, 2'b10, 16'h0000, 1'b1, 16'hBE34, 1'b0, 1'b1); idle(2);
    cpu_access("rd_rom_1",      1'b1, 23'h7E0000, 2'b11, 16'h0000, 1'b1, 16'h4E75, 1'b1, 1'b0); idle(2);
    cpu_access("rd_rom_2",      1'b1, 23'h7E0000, 2'b11, 16'h0000, 1'b1, 16'h4E75, 1'b1, 1'b0); idle(2);

    dis_in_fill = 1'b1;
    cpu_access("rd_disable_mid",1'b1, 23'h000100, 2'b11, 16'h0000, 1'b1, 16'hCAFE, 1'b1, 1'b0);
    @(negedge clk);
    flush_count("disable_flush_cycles");
    dis_in_fill = 1'b0;
    idle(3);
    cpu_access("rd_after_flush",1'b1, 23'h000080, 2'b11, 16'h0000, 1'b1, 16'hBE34, 1'b1, 1'b0); idle(5);

    push_aux("cpu_exp_left", cpu_q.size(), 0);
    push_aux("ram_exp_left", ram_q.size(), 0);
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mste_cache_sequencer.md
Name: mste_cache_sequencer

Overview:
- Direct-mapped, write-through CPU cache controller for the Mega STE. Sits between the 68000 bus interface and the shared RAM/ROM bus controller.
- Gated by the enable_cache bit from the Mega STE config register.
- Sequences lookup, line fill and write-through, plus invalidate sweeps on disable.
- Snoops DMA/blitter writes to keep the cache coherent.

Parameters:
- IDX_BITS, 13, index width; 2^13 entries of one 16-bit word each (16 KB).
- CACHE_TOP, 24'h400000, byte addresses below this are cacheable (ST RAM). All others pass through uncached.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable_cache  in  1  cache enable from config register
- cpu_req  in  1  CPU bus cycle request; held until cpu_ack
- cpu_rw  in  1  1=read, 0=write
- cpu_addr  in  23  word address [23:1]
- cpu_ds  in  2  byte strobes {UDS,LDS}, active-high
- cpu_wdata  in  16  write data
- cpu_rdata  out  16  read data, valid when cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse
- ram_req  out  1  memory request; held until ram_ack
- ram_rw  out  1  1=read
- ram_addr  out  23  word address
- ram_ds  out  2  byte strobes
- ram_wdata  out  16  write data
- ram_rdata  in  16  read data, valid with ram_ack
- ram_ack  in  1  one-cycle memory completion
- snoop_we  in  1  another master writes memory this cycle
- snoop_addr  in  23  word address of that write
- flushing  out  1  high while invalidate sweep is running

Behaviour:
- Reset values: cpu_ack=0, cpu_rdata=0, ram_req=0, ram_rw=1, ram_addr=0, ram_ds=0, ram_wdata=0. flushing=1; state enters FLUSH.
- Storage: valid[2^IDX_BITS], tag[2^IDX_BITS] of width 23-IDX_BITS, data[2^IDX_BITS] x 16. Index = cpu_addr[IDX_BITS:1]; tag = upper bits.
- States: FLUSH, IDLE, LOOKUP, FILL, WTHRU, DONE.
- FLUSH:
  - Clears one valid bit per cycle using a sweep counter from 0 to 2^IDX_BITS-1, then goes to IDLE.
  - Entered from reset, and from IDLE on a 1->0 edge of enable_cache (registered).
  - A disable edge during any other state is latched as pending_flush; the flush runs after the current access reaches DONE.
  - cpu_req is not accepted during FLUSH.
- IDLE: on cpu_req go to LOOKUP (1 cycle, synchronous array read).
- LOOKUP:
  - Cacheable = enable_cache=1 and addr<CACHE_TOP.
  - Read, cacheable, hit (valid & tag match): cpu_rdata=data, go to DONE. Hit latency is 2 cycles from req to ack.
  - Read otherwise: go to FILL. Drive ram_req=1, ram_rw=1, ram_ds=2'b11 (full word always fetched).
  - Write: go to WTHRU with ram_req=1, ram_rw=0, ram_ds=cpu_ds, ram_wdata=cpu_wdata.
- FILL: on ram_ack:
  - cpu_rdata=ram_rdata; drop ram_req; go to DONE.
  - If cacheable and no fill-kill: data/tag written, valid set.
- WTHRU: on ram_ack go to DONE. If cacheable and hit, merge the strobed bytes into data; a miss does not allocate.
- DONE: cpu_ack=1 for exactly one cycle, then IDLE (or FLUSH if pending_flush).
- Snoop:
  - Any cycle with snoop_we=1 and valid/tag match at snoop_addr index clears that valid bit.
  - Snoop clears have priority over a same-cycle valid set.
  - Snoop to the index/tag being filled during FILL sets fill-kill: the fill data is returned to the CPU but not cached.
  - Snoop during FLUSH is ignored; the sweep covers it.
- Uncached mode (enable_cache=0): every read goes to FILL without allocation. Valid bits are never set.
- Reset mid-operation aborts any RAM cycle immediately (ram_req=0) and restarts FLUSH.
- Byte read with cpu_ds=2'b10 still returns the full word; the CPU bus selects the byte.

Decomposition:
- Shared package mste_pkg: state enum, IDX_BITS/CACHE_TOP defaults, and a tag-width function.
- Natural sub-module: mste_cache_ram, a dual-port tag+valid+data array. One port serves lookup/fill; the other serves snoop compare/clear and flush sweep.

Test Plan:
- Reset, then cpu_req read 0x000100 with enable_cache=1 -> flushing high 8192 cycles; read misses; ram_req with ram_addr=0x000080; ram_rdata=0xBEEF returned; cpu_ack.
- Repeat read 0x000100 -> no ram_req; cpu_ack exactly 2 cycles after cpu_req with cpu_rdata=0xBEEF.
- Write 0x000100 ds=2'b01 data 0x1234 -> ram write ds=01; subsequent read hit returns 0xBE34, no ram_req.
- snoop_we at addr 0x000080 (word address), then read 0x000100 -> miss, ram_req issued. Snoop during FILL of the same line -> data returned but next read misses again.
- Read 0xFC0000 (ROM, above CACHE_TOP) twice -> two ram_req cycles, never a hit.
- enable_cache 1->0 while FILL in progress -> access completes with cpu_ack. FLUSH then runs; flushing=1 for 8192 cycles. Next read of 0x000100 misses.
